alu_issue_ctrl: RTL and testbench

Sequencing front-end that sits between the execute stage and the combinational ALU. It accepts one ALU request at a time over a valid/ready handshake and owns the architectural processor-flags register. It drives the ALU's oper/a_in/b_in/proc_flags_in and captures out/proc_flags_out. It also implements rol/ror as a three-pass ALU sequence, and it returns the result over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready front-end for a combinational ALU that owns the flags register
// and sequences rol/ror as lsl/lsr/orr passes.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int OPER_WIDTH  = 4,
    parameter int FLAGS_WIDTH = 4,
    parameter int FLAG_Z      = 0,
    parameter int FLAG_C      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [OPER_WIDTH-1:0]  req_oper,
    input  logic [DATA_WIDTH-1:0]  req_a,
    input  logic [DATA_WIDTH-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_result,
    output logic [FLAGS_WIDTH-1:0] flags,
    output logic [OPER_WIDTH-1:0]  alu_oper,
    output logic [DATA_WIDTH-1:0]  alu_a,
    output logic [DATA_WIDTH-1:0]  alu_b,
    output logic [FLAGS_WIDTH-1:0] alu_flags_in,
    input  logic [DATA_WIDTH-1:0]  alu_out,
    input  logic [FLAGS_WIDTH-1:0] alu_flags_out
);
    localparam logic [OPER_WIDTH-1:0] OP_ORR = OPER_WIDTH'(5);
    localparam logic [OPER_WIDTH-1:0] OP_CMP = OPER_WIDTH'(7);
    localparam logic [OPER_WIDTH-1:0] OP_LSL = OPER_WIDTH'(8);
    localparam logic [OPER_WIDTH-1:0] OP_LSR = OPER_WIDTH'(9);
    localparam logic [OPER_WIDTH-1:0] OP_ASR = OPER_WIDTH'(10);
    localparam logic [OPER_WIDTH-1:0] OP_ROL = OPER_WIDTH'(11);
    localparam logic [OPER_WIDTH-1:0] OP_ROR = OPER_WIDTH'(12);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, EXEC, ROT1, ROT2, ROT3, RESP} state_t;

    state_t state, state_nxt;
    logic [OPER_WIDTH-1:0] oper_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, t1, t2, n, m;
    logic req_rot, req_shift, bypass, left;

    // rotate amount is b mod DATA_WIDTH; n is never zero once a rotate reaches ROT1
    assign n         = {{(DATA_WIDTH-SW){1'b0}}, b_q[SW-1:0]};
    assign m         = DATA_WIDTH'(DATA_WIDTH) - n;
    assign left      = oper_q == OP_ROL;
    assign req_rot   = req_oper == OP_ROL || req_oper == OP_ROR;
    assign req_shift = req_oper == OP_LSL || req_oper == OP_LSR || req_oper == OP_ASR;
    assign bypass    = (req_shift && req_b == '0) || (req_rot && req_b[SW-1:0] == '0);

    assign req_ready    = state == IDLE;
    assign rsp_valid    = state == RESP;
    assign alu_flags_in = flags;

    always_comb begin
        state_nxt = state;
        alu_oper  = '0;
        alu_a     = '0;
        alu_b     = '0;
        unique case (state)
            IDLE: if (req_valid) state_nxt = bypass ? RESP : (req_rot ? ROT1 : EXEC);
            EXEC: begin
                alu_oper  = oper_q;
                alu_a     = a_q;
                alu_b     = b_q;
                state_nxt = RESP;
            end
            ROT1: begin
                alu_oper  = left ? OP_LSL : OP_LSR;
                alu_a     = a_q;
                alu_b     = n;
                state_nxt = ROT2;
            end
            ROT2: begin
                alu_oper  = left ? OP_LSR : OP_LSL;
                alu_a     = a_q;
                alu_b     = m;
                state_nxt = ROT3;
            end
            ROT3: begin
                alu_oper  = OP_ORR;
                alu_a     = t1;
                alu_b     = t2;
                state_nxt = RESP;
            end
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            oper_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            t1         <= '0;
            t2         <= '0;
            rsp_result <= '0;
            flags      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    oper_q <= req_oper;
                    a_q    <= req_a;
                    b_q    <= req_b;
                    if (bypass) rsp_result <= req_a;
                end
                EXEC: begin
                    rsp_result <= oper_q == OP_CMP ? a_q : alu_out;
                    flags      <= alu_flags_out;
                end
                ROT1: t1 <= alu_out;
                ROT2: t2 <= alu_out;
                ROT3: begin
                    rsp_result    <= alu_out;
                    flags[FLAG_Z] <= alu_out == '0;
                    flags[FLAG_C] <= left ? alu_out[0] : alu_out[DATA_WIDTH-1];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with a behavioural ALU model; flags are {V,N,C,Z} with C=bit1, Z=bit0.
module tb_alu_issue_ctrl;
    localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, SBC = 4'd3, AND_ = 4'd4, ORR = 4'd5,
                           EOR = 4'd6, CMP = 4'd7, LSL = 4'd8, LSR = 4'd9, ROL = 4'd11, ROR = 4'd12;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
    logic [3:0]  req_oper = '0, flags, alu_oper, alu_flags_in, alu_flags_out;
    logic [15:0] req_a = '0, req_b = '0, rsp_result, alu_a, alu_b, alu_out;
    logic [16:0] w;
    logic [31:0] sh;
    logic        c;
    int          n_checks = 0, n_fail = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_oper(req_oper),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .flags(flags), .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b),
        .alu_flags_in(alu_flags_in), .alu_out(alu_out), .alu_flags_out(alu_flags_out)
    );

    always #5 clk = ~clk;

    // ALU model: C is carry out for add, not-borrow for subtract, last bit shifted out for shifts
    always_comb begin
        w  = '0;
        sh = '0;
        c  = alu_flags_in[1];
        alu_out = '0;
        case (alu_oper)
            ADD: begin w = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = w[15:0]; c = w[16]; end
            ADC: begin w = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_flags_in[1]}; alu_out = w[15:0]; c = w[16]; end
            SUB, CMP: begin w = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1; alu_out = w[15:0]; c = w[16]; end
            SBC: begin w = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'd0, alu_flags_in[1]}; alu_out = w[15:0]; c = w[16]; end
            AND_: alu_out = alu_a & alu_b;
            ORR: alu_out = alu_a | alu_b;
            EOR: alu_out = alu_a ^ alu_b;
            LSL: begin sh = {16'd0, alu_a} << alu_b; alu_out = sh[15:0]; c = sh[16]; end
            LSR: begin sh = {alu_a, 16'd0} >> alu_b; alu_out = sh[31:16]; c = sh[15]; end
            default: ;
        endcase
        alu_flags_out = {alu_flags_in[3:2], c, alu_out == 16'd0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // issues one request, measures accept-to-rsp_valid latency (counting the accept edge), optionally takes the response
    task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input logic [15:0] exp_res, input logic [3:0] exp_flags, input bit take);
        int k = 0;
        int lat = 1;
        logic [3:0] pre;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        pre = flags;
        req_valid = 1; req_oper = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 0; req_oper = '0; req_a = 16'hDEAD; req_b = 16'hBEEF;
        chk({tag, " busy"}, {31'd0, req_ready}, 32'd0);
        while (!rsp_valid && lat < 20) begin
            chk({tag, " flags hold"}, {28'd0, flags}, {28'd0, pre});
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, {16'd0, rsp_result}, {16'd0, exp_res});
        chk({tag, " flags"}, {28'd0, flags}, {28'd0, exp_flags});
        if (take) begin
            rsp_ready = 1;
            @(posedge clk); #1;
            rsp_ready = 0;
            chk({tag, " rsp taken"}, {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset flags", {28'd0, flags}, 32'd0);
        chk("reset result", {16'd0, rsp_result}, 32'd0);
        chk("reset alu_a", {16'd0, alu_a}, 32'd0);
        rst = 0;
        @(posedge clk); #1;

        do_op("add", ADD, 16'hFFFF, 16'h0001, 2, 16'h0000, 4'b0011, 1);
        do_op("adc", ADC, 16'h0001, 16'h0001, 2, 16'h0003, 4'b0000, 1);
        do_op("rol", ROL, 16'h8001, 16'd1, 4, 16'h0003, 4'b0010, 1);
        do_op("ror", ROR, 16'h0001, 16'd17, 4, 16'h8000, 4'b0010, 1);
        do_op("preset", ADD, 16'hFFFF, 16'h0001, 2, 16'h0000, 4'b0011, 1);
        do_op("lsl0", LSL, 16'h1234, 16'd0, 1, 16'h1234, 4'b0011, 1);
        do_op("sub", SUB, 16'h0003, 16'h0005, 2, 16'hFFFE, 4'b0000, 1);

        // cmp with a stalled consumer and a competing request held on the input
        do_op("cmp", CMP, 16'd5, 16'd5, 2, 16'h0005, 4'b0011, 0);
        req_valid = 1; req_oper = ADD; req_a = 16'd1; req_b = 16'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("cmp stall valid", {31'd0, rsp_valid}, 32'd1);
            chk("cmp stall result", {16'd0, rsp_result}, 32'h5);
            chk("cmp stall ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("cmp handshake valid", {31'd0, rsp_valid}, 32'd0);
        chk("cmp handshake idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 0;
        chk("held req accepted", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("held req valid", {31'd0, rsp_valid}, 32'd1);
        chk("held req result", {16'd0, rsp_result}, 32'h3);
        chk("held req flags", {28'd0, flags}, 32'h0);
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;

        // flags = 0011 from a preset, then reset lands in ROT2 of a rotate
        do_op("preset2", ADD, 16'hFFFF, 16'h0001, 2, 16'h0000, 4'b0011, 1);
        req_valid = 1; req_oper = ROL; req_a = 16'h00F0; req_b = 16'd4;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        chk("rot2 alu_oper", {28'd0, alu_oper}, {28'd0, LSR});
        chk("rot2 alu_b", {16'd0, alu_b}, 32'd12);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort flags", {28'd0, flags}, 32'd0);
        chk("abort alu_oper", {28'd0, alu_oper}, 32'd0);
        do_op("rol reissue", ROL, 16'h00F0, 16'd4, 4, 16'h0F00, 4'b0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
